// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader.
// Receives a 4-byte little-endian length header followed by the payload over
// a byte-wide valid/ready stream, packs payload bytes little-endian into
// 32-bit words and writes each word to instruction memory starting at
// BASE_ADDR. busy holds the core in reset while a load is in progress.
//
// Handshake: a byte moves on a rising edge where rx_valid_i && rx_ready_o.
// rx_ready_o is registered and is high only in LEN and DATA; a byte offered
// while rx_ready_o is low is left untouched for the upstream FIFO to hold.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned MAX_BYTES = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] len_q, len_d;
  logic [1:0]  hdr_idx_q, hdr_idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] word_idx_q, word_idx_d;
  logic [31:0] pack_q, pack_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic        rx_ready_q, rx_ready_d;
  logic        mem_we_q, mem_we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        accept;

  assign accept = rx_valid_i && rx_ready_q;

  // Next-state, datapath updates and registered-output targets.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    hdr_idx_d   = hdr_idx_q;
    cnt_d       = cnt_q;
    word_idx_d  = word_idx_q;
    pack_d      = pack_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d    = S_LEN;
          len_d      = 32'd0;
          hdr_idx_d  = 2'd0;
          cnt_d      = 32'd0;
          word_idx_d = 32'd0;
          pack_d     = 32'd0;
        end
      end
      S_LEN: begin
        if (accept) begin
          // Header arrives LSB first: shift each byte in from the top.
          len_d     = {rx_data_i, len_q[31:8]};
          hdr_idx_d = hdr_idx_q + 2'd1;
          if (hdr_idx_q == 2'd3) begin
            if (len_d == 32'd0)            state_d = S_DONE;
            else if (len_d > MAX_BYTES)    state_d = S_ERR;
            else                           state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          case (cnt_q[1:0])
            2'd0:    pack_d[7:0]   = rx_data_i;
            2'd1:    pack_d[15:8]  = rx_data_i;
            2'd2:    pack_d[23:16] = rx_data_i;
            default: pack_d[31:24] = rx_data_i;
          endcase
          cnt_d = cnt_q + 32'd1;
          if (cnt_q[1:0] == 2'd3 || cnt_d == len_q) begin
            state_d     = S_WRITE;
            mem_addr_d  = BASE_ADDR + {word_idx_q[29:0], 2'b00};
            mem_wdata_d = pack_d;
            case (cnt_q[1:0])
              2'd0:    mem_wstrb_d = 4'b0001;
              2'd1:    mem_wstrb_d = 4'b0011;
              2'd2:    mem_wstrb_d = 4'b0111;
              default: mem_wstrb_d = 4'b1111;
            endcase
          end
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + 32'd1;
        pack_d     = 32'd0;
        state_d    = (cnt_q == len_q) ? S_DONE : S_DATA;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered copies of what the next state implies.
    rx_ready_d = (state_d == S_LEN) || (state_d == S_DATA);
    mem_we_d   = (state_d == S_WRITE);
    busy_d     = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERR);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q       <= 32'd0;
      hdr_idx_q   <= 2'd0;
      cnt_q       <= 32'd0;
      word_idx_q  <= 32'd0;
      pack_q      <= 32'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wstrb_q <= 4'd0;
      rx_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      len_q       <= len_d;
      hdr_idx_q   <= hdr_idx_d;
      cnt_q       <= cnt_d;
      word_idx_q  <= word_idx_d;
      pack_q      <= pack_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      rx_ready_q  <= rx_ready_d;
      mem_we_q    <= mem_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign rx_ready_o  = rx_ready_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wstrb_o = mem_wstrb_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives header/payload byte streams,
// captures every memory write and compares against hand-computed writes.
module tb_imem_loader;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  state;

  imem_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .rx_valid_i  (rx_valid),
    .rx_data_i   (rx_data),
    .rx_ready_o  (rx_ready),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_wstrb_o (mem_wstrb),
    .busy_o      (busy),
    .done_o      (done),
    .error_o     (error),
    .state_o     (state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard: {addr, wdata, wstrb}
  logic [67:0] exp_q[$];
  logic [67:0] got_q[$];
  logic [7:0]  stim_q[$];

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      got_q.push_back({mem_addr, mem_wdata, mem_wstrb});
      check("rx_ready_low_in_write", 80'(rx_ready), 80'(0));
    end
  end

  // Driver tasks (all called at a falling edge, return at a falling edge)
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int  t;
    logic r;
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    forever begin
      r = rx_ready;
      @(negedge clk);
      if (r) break;
      t++;
      if (t > 50) begin
        check("byte_accept_timeout", 80'(1), 80'(0));
        break;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_len(input logic [31:0] l);
    send_byte(l[7:0]);
    send_byte(l[15:8]);
    send_byte(l[23:16]);
    send_byte(l[31:24]);
  endtask

  // Sends stim_q; random gaps up to gap_max, optional start pulse after byte 2.
  task automatic send_payload(input int gap_max, input bit mid_start);
    for (int i = 0; i < stim_q.size(); i++) begin
      send_byte(stim_q[i]);
      if (mid_start && i == 2) pulse_start();
      if (i != stim_q.size() - 1) repeat ($urandom_range(0, gap_max)) @(negedge clk);
    end
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_count"}, 80'(got_q.size()), 80'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_write"}, 80'(got_q[i]), 80'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic set_prog8();
    stim_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
  endtask

  task automatic exp_prog8();
    exp_q.push_back({32'h8000_0000, 32'h0000_0013, 4'b1111});
    exp_q.push_back({32'h8000_0004, 32'h0000_006F, 4'b1111});
  endtask

  // Full 8-byte load and end-of-load checks.
  task automatic run_prog8(input string tag, input int gap_max, input bit mid_start);
    pulse_start();
    check({tag, "_ready_busy_after_start"}, 80'({rx_ready, busy, done, error}), 80'(4'b1100));
    send_len(32'd8);
    set_prog8();
    send_payload(gap_max, mid_start);
    check({tag, "_we_after_last_byte"}, 80'({mem_we, done, rx_ready}), 80'(3'b100));
    @(negedge clk);
    check({tag, "_end_flags"}, 80'({done, busy, error, mem_we}), 80'(4'b1000));
    exp_prog8();
    check_writes(tag);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #1;
    check("reset_outputs",
          80'({rx_ready, mem_we, mem_addr, mem_wdata, mem_wstrb, busy, done, error, state}), 80'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: two full words, rx_valid back to back
    run_prog8("prog8", 0, 1'b0);

    // 2: L=5, partial final word
    pulse_start();
    send_len(32'd5);
    stim_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_payload(0, 1'b0);
    @(negedge clk);
    check("len5_end_flags", 80'({done, busy, error}), 80'(3'b100));
    exp_q.push_back({32'h8000_0000, 32'h0403_0201, 4'b1111});
    exp_q.push_back({32'h8000_0004, 32'h0000_0005, 4'b0001});
    check_writes("len5");

    // 3: L=0, done in the cycle after the 4th header byte
    pulse_start();
    check("len0_done_cleared", 80'(done), 80'(0));
    send_len(32'd0);
    check("len0_done_flags", 80'({done, busy, error, rx_ready}), 80'(4'b1000));
    repeat (3) @(negedge clk);
    check_writes("len0");

    // 4: oversize header rejected, stray bytes not consumed, then recovery
    pulse_start();
    send_len(32'h0000_4001);
    check("oversize_flags", 80'({error, done, busy, rx_ready}), 80'(4'b1000));
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    repeat (4) @(negedge clk);
    rx_valid = 1'b0;
    check("oversize_still_err", 80'(error), 80'(1));
    check_writes("oversize");
    pulse_start();
    check("oversize_error_cleared", 80'({error, busy}), 80'(2'b01));
    send_len(32'd5);
    stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_payload(0, 1'b0);
    @(negedge clk);
    check("recover_end_flags", 80'({done, error, busy}), 80'(3'b100));
    exp_q.push_back({32'h8000_0000, 32'h4433_2211, 4'b1111});
    exp_q.push_back({32'h8000_0004, 32'h0000_0055, 4'b0001});
    check_writes("recover");

    // 5: random gaps plus a mid-load start pulse
    run_prog8("gaps_midstart", 3, 1'b1);

    // 6: reset after 6 payload bytes, then full reload
    pulse_start();
    send_len(32'd8);
    set_prog8();
    for (int i = 0; i < 6; i++) send_byte(stim_q[i]);
    #2 rst_n = 1'b0;
    #1;
    check("midload_reset_outputs",
          80'({rx_ready, mem_we, mem_addr, mem_wdata, mem_wstrb, busy, done, error, state}), 80'(0));
    exp_q.push_back({32'h8000_0000, 32'h0000_0013, 4'b1111});
    check_writes("before_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_prog8("reload", 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Overall time bound
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
